// File: rtl/pwm_seq_pkg.sv
// Shared types and defaults for the PWM duty sequencer.
// Provides the FSM state enum and default WIDTH / STEP_W values.
package pwm_seq_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STEP_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        HOLD,
        STOP
    } state_t;

endpackage

// File: rtl/pwm_step_sat.sv
// Combinational saturating step of cur toward tgt by step.
// Ports: cur, tgt, step in; nxt (next value), reached (nxt == tgt) out.
module pwm_step_sat
    import pwm_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic [WIDTH-1:0]  cur,
    input  logic [WIDTH-1:0]  tgt,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  nxt,
    output logic              reached
);

    logic [WIDTH:0] diff;
    logic [WIDTH:0] stp;
    logic           up;

    always_comb begin
        up   = tgt > cur;
        diff = up ? ({1'b0, tgt} - {1'b0, cur})
                  : ({1'b0, cur} - {1'b0, tgt});
        stp  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
        reached = diff <= stp;
        // When not reached, stp < diff, so a full step can
        // neither overshoot the target nor wrap the range.
        if (reached) begin
            nxt = tgt;
        end else if (up) begin
            nxt = cur + stp[WIDTH-1:0];
        end else begin
            nxt = cur - stp[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Soft-start / soft-retarget duty ramp controller for an 8-bit PWM.
// Ports: clk, rst (async active-low), start, stop, target, step,
//        period_tick in; duty, busy, done out (all registered).
// Option: PWM_SEQ_SOFT_STOP_EN makes stop ramp down via STOP state.
module pwm_duty_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [WIDTH-1:0]  target,
    input  logic [STEP_W-1:0] step,
    input  logic              period_tick,
    output logic [WIDTH-1:0]  duty,
    output logic              busy,
    output logic              done
);

    state_t              state;
    state_t              state_n;
    logic [WIDTH-1:0]    tgt_q;
    logic [WIDTH-1:0]    tgt_n;
    logic [STEP_W-1:0]   step_q;
    logic [STEP_W-1:0]   step_n;
    logic [WIDTH-1:0]    duty_n;
    logic                busy_n;
    logic                done_n;
    logic [WIDTH-1:0]    sat_tgt;
    logic [WIDTH-1:0]    sat_nxt;
    logic                sat_hit;
    logic                stop_hit;
    logic                start_ok;

`ifdef PWM_SEQ_SOFT_STOP_EN
    assign sat_tgt = (state == STOP) ? '0 : tgt_q;
`else
    assign sat_tgt = tgt_q;
`endif

    pwm_step_sat #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_sat (
        .cur     (duty),
        .tgt     (sat_tgt),
        .step    (step_q),
        .nxt     (sat_nxt),
        .reached (sat_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            tgt_q  <= '0;
            step_q <= STEP_W'(1);
            duty   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            tgt_q  <= tgt_n;
            step_q <= step_n;
            duty   <= duty_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        tgt_n   = tgt_q;
        step_n  = step_q;
        duty_n  = duty;
        done_n  = 1'b0;

`ifdef PWM_SEQ_SOFT_STOP_EN
        stop_hit = stop && (state != IDLE) && (state != STOP);
        start_ok = start && (state != STOP);
`else
        stop_hit = stop && (state != IDLE);
        start_ok = start;
`endif

        if (stop_hit) begin
`ifdef PWM_SEQ_SOFT_STOP_EN
            state_n = STOP;
`else
            state_n = IDLE;
            duty_n  = '0;
`endif
        end else if (start_ok) begin
            tgt_n  = target;
            step_n = (step == '0) ? STEP_W'(1) : step;
            if (target == duty) begin
                state_n = HOLD;
                done_n  = 1'b1;
            end else begin
                state_n = RAMP;
            end
        end else if (period_tick) begin
            unique case (state)
                RAMP: begin
                    duty_n = sat_nxt;
                    if (sat_hit) begin
                        state_n = HOLD;
                        done_n  = 1'b1;
                    end
                end
`ifdef PWM_SEQ_SOFT_STOP_EN
                STOP: begin
                    duty_n = sat_nxt;
                    if (sat_hit) begin
                        state_n = IDLE;
                    end
                end
`endif
                default: begin
                end
            endcase
        end

        busy_n = (state_n == RAMP) || (state_n == STOP);
    end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer (vectors, corners, random).
// Honours PWM_SEQ_SOFT_STOP_EN the same way as the design.
module tb_pwm_duty_sequencer;

`ifdef PWM_SEQ_SOFT_STOP_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_HOLD = 2;
    localparam int M_STOP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] target = '0;
    logic [3:0] step = '0;
    logic       period_tick = 1'b0;
    logic [7:0] duty;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    int m_mode, m_duty, m_tgt, m_stp, m_done;

    pwm_duty_sequencer #(.WIDTH(8), .STEP_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .target      (target),
        .step        (step),
        .period_tick (period_tick),
        .duty        (duty),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       sp;
        logic [7:0] tg;
        logic [3:0] se;
        logic       tk;
        logic [7:0] ed;
        logic       eb;
        logic       edn;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(logic st, logic sp, logic [7:0] tg,
                                logic [3:0] se, logic tk,
                                logic [7:0] ed, logic eb,
                                logic edn);
        vec_t v;
        v.st = st; v.sp = sp; v.tg = tg; v.se = se; v.tk = tk;
        v.ed = ed; v.eb = eb; v.edn = edn;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_duty = 0;
        m_tgt  = 0;
        m_stp  = 1;
        m_done = 0;
    endtask

    // Behavioural reference: one clock of the sequencer's rules.
    task automatic model_step(input logic st, input logic sp,
                              input int tg, input int se,
                              input logic tk);
        int diff;
        m_done = 0;
        if (sp && m_mode != M_IDLE && !(SOFT && m_mode == M_STOP)) begin
            if (SOFT) begin
                m_mode = M_STOP;
            end else begin
                m_mode = M_IDLE;
                m_duty = 0;
            end
        end else if (st && m_mode != M_STOP) begin
            m_tgt = tg;
            m_stp = (se == 0) ? 1 : se;
            if (m_tgt == m_duty) begin
                m_mode = M_HOLD;
                m_done = 1;
            end else begin
                m_mode = M_RAMP;
            end
        end else if (tk) begin
            if (m_mode == M_RAMP) begin
                diff = m_tgt - m_duty;
                if (diff <= m_stp && -diff <= m_stp) begin
                    m_duty = m_tgt;
                    m_mode = M_HOLD;
                    m_done = 1;
                end else begin
                    m_duty += (diff > 0) ? m_stp : -m_stp;
                end
            end else if (m_mode == M_STOP) begin
                m_duty = (m_duty > m_stp) ? m_duty - m_stp : 0;
                if (m_duty == 0) m_mode = M_IDLE;
            end
        end
    endtask

    task automatic cyc(input logic st, input logic sp,
                       input logic [7:0] tg, input logic [3:0] se,
                       input logic tk, input string nm);
        start = st; stop = sp; target = tg; step = se;
        period_tick = tk;
        @(posedge clk);
        #1;
        model_step(st, sp, int'(tg), int'(se), tk);
        start = 1'b0; stop = 1'b0; period_tick = 1'b0;
        chk({nm, "_duty"}, int'(duty), m_duty);
        chk({nm, "_busy"}, int'(busy),
            (m_mode == M_RAMP || m_mode == M_STOP) ? 1 : 0);
        chk({nm, "_done"}, int'(done), m_done);
    endtask

    task automatic tick_until_done(input string nm, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 4'h0, 1'b1, nm);
            if (done) seen = 1;
        end
        chk({nm, "_reached"}, int'(seen), 1);
    endtask

    initial begin
        int ndone;
        model_reset();
        #12;
        chk("rst_duty", int'(duty), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset mid-ramp at duty 0x40.
        cyc(1'b1, 1'b0, 8'h80, 4'd8, 1'b0, "mr_start");
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b0, 8'h00, 4'h0, 1'b1, "mr_tick");
        chk("mr_at40", int'(duty), 8'h40);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_async_duty", int'(duty), 0);
        chk("mr_async_busy", int'(busy), 0);
        chk("mr_async_done", int'(done), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b0, 1'b0, 8'h00, 4'h0, 1'b1, "mr_idle");

        tbl[0]  = mk(1, 0, 8'h10, 4'd4, 0, 8'h00, 1, 0);
        tbl[1]  = mk(0, 0, 8'h00, 4'd0, 1, 8'h04, 1, 0);
        tbl[2]  = mk(0, 0, 8'h00, 4'd0, 1, 8'h08, 1, 0);
        tbl[3]  = mk(0, 0, 8'h00, 4'd0, 1, 8'h0C, 1, 0);
        tbl[4]  = mk(0, 0, 8'h00, 4'd0, 1, 8'h10, 0, 1);
        tbl[5]  = mk(0, 0, 8'h00, 4'd0, 0, 8'h10, 0, 0);
        tbl[6]  = mk(0, 0, 8'h00, 4'd0, 1, 8'h10, 0, 0);
        tbl[7]  = mk(1, 0, 8'h03, 4'd5, 0, 8'h10, 1, 0);
        tbl[8]  = mk(0, 0, 8'h00, 4'd0, 1, 8'h0B, 1, 0);
        tbl[9]  = mk(0, 0, 8'h00, 4'd0, 1, 8'h06, 1, 0);
        tbl[10] = mk(0, 0, 8'h00, 4'd0, 1, 8'h03, 0, 1);
        tbl[11] = mk(1, 0, 8'h06, 4'd0, 0, 8'h03, 1, 0);
        tbl[12] = mk(0, 0, 8'h00, 4'd0, 1, 8'h04, 1, 0);
        tbl[13] = mk(1, 0, 8'h05, 4'd2, 1, 8'h04, 1, 0);
        tbl[14] = mk(0, 0, 8'h00, 4'd0, 1, 8'h05, 0, 1);
        tbl[15] = mk(1, 0, 8'h05, 4'd9, 0, 8'h05, 0, 1);
        tbl[16] = mk(0, 0, 8'h00, 4'd0, 1, 8'h05, 0, 0);

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].st, tbl[i].sp, tbl[i].tg, tbl[i].se,
                tbl[i].tk, "vec");
            chk($sformatf("vec%0d_duty", i), int'(duty), int'(tbl[i].ed));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].eb));
            chk($sformatf("vec%0d_done", i), int'(done), int'(tbl[i].edn));
        end

        // Ticks spaced 8 clocks apart; exactly one done.
        cyc(1'b1, 1'b0, 8'h15, 4'd4, 1'b0, "sp_start");
        ndone = 0;
        for (int t = 0; t < 4; t++) begin
            for (int g = 0; g < 7; g++)
                cyc(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, "sp_gap");
            cyc(1'b0, 1'b0, 8'h00, 4'h0, 1'b1, "sp_tick");
            if (done) ndone++;
        end
        chk("sp_final", int'(duty), 8'h15);
        chk("sp_done_cnt", ndone, 1);

        // High-end saturation.
        cyc(1'b1, 1'b0, 8'hF0, 4'd15, 1'b0, "hi_start");
        tick_until_done("hi_f0", 40);
        chk("hi_f0_val", int'(duty), 8'hF0);
        cyc(1'b1, 1'b0, 8'hFE, 4'd15, 1'b0, "hi_fe_start");
        cyc(1'b0, 1'b0, 8'h00, 4'h0, 1'b1, "hi_fe_tick");
        chk("hi_fe_val", int'(duty), 8'hFE);
        chk("hi_fe_done", int'(done), 1);
        cyc(1'b1, 1'b0, 8'hFF, 4'd0, 1'b0, "hi_ff_start");
        cyc(1'b0, 1'b0, 8'h00, 4'h0, 1'b1, "hi_ff_tick");
        chk("hi_ff_val", int'(duty), 8'hFF);
        cyc(1'b1, 1'b0, 8'hFF, 4'd3, 1'b0, "hi_eq");
        chk("hi_eq_done", int'(done), 1);
        chk("hi_eq_busy", int'(busy), 0);
        cyc(1'b1, 1'b0, 8'h00, 4'd15, 1'b0, "lo_start");
        tick_until_done("lo_00", 40);
        chk("lo_00_val", int'(duty), 0);

        // Stop from 0x20 with step 8.
        cyc(1'b1, 1'b0, 8'h20, 4'd8, 1'b0, "st_start");
        tick_until_done("st_up", 10);
        cyc(1'b0, 1'b1, 8'h00, 4'h0, 1'b0, "st_stop");
`ifdef PWM_SEQ_SOFT_STOP_EN
        chk("st_soft_hold", int'(duty), 8'h20);
        chk("st_soft_busy", int'(busy), 1);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 4'h0, 1'b1, "st_down");
            chk($sformatf("st_down%0d", i), int'(duty), 8'h18 - 8 * i);
            if (done) ndone++;
        end
        chk("st_soft_idle", int'(busy), 0);
        chk("st_soft_nodone", ndone, 0);
`else
        chk("st_hard_duty", int'(duty), 0);
        chk("st_hard_busy", int'(busy), 0);
`endif

        // Same-cycle start and stop from RAMP: stop wins.
        cyc(1'b1, 1'b0, 8'h30, 4'd15, 1'b0, "ss_start");
        cyc(1'b0, 1'b0, 8'h00, 4'h0, 1'b1, "ss_tick");
        cyc(1'b1, 1'b1, 8'h80, 4'd1, 1'b0, "ss_both");
`ifdef PWM_SEQ_SOFT_STOP_EN
        chk("ss_soft_duty", int'(duty), 8'h0F);
        chk("ss_soft_busy", int'(busy), 1);
        cyc(1'b1, 1'b0, 8'h80, 4'd1, 1'b1, "ss_ign_start");
        chk("ss_ign_duty", int'(duty), 8'h00);
        chk("ss_ign_busy", int'(busy), 0);
`else
        chk("ss_hard_duty", int'(duty), 0);
        chk("ss_hard_busy", int'(busy), 0);
`endif

        // Random stimulus against the reference model.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(15) == 0), ($urandom_range(39) == 0),
                8'($urandom), 4'($urandom), ($urandom_range(2) == 0),
                "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
